pipe_register: RTL and testbench

- Parametrised pipeline register with full valid/ready handshake. It replaces bare enable-gated registers wherever data crosses a pipeline boundary under backpressure.
- Built as a chain of STAGES skid slices. It sustains 1 transfer/cycle with no combinational path from out_ready to in_ready.
- Sits between datapath units, for example the ALU result to the writeback path.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/skid_slice.sv | 72 +++++++
 rtl/pipe_register.sv | 104 ++++++++++
 tb/tb_pipe_register.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_register chain: count sizing, even parity, reset data value.
package pipe_pkg;

    localparam int unsigned PAR_MAX_W = 1024;
    localparam logic        RST_DATA  = 1'b0;

    function automatic int unsigned cnt_width(int unsigned stages);
        return $clog2(2 * stages + 1);
    endfunction

    // Callers zero-extend to PAR_MAX_W; zero padding leaves the XOR unchanged.
    function automatic logic even_parity(logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/skid_slice.sv
// One main/skid register pair with a valid/ready handshake; ready depends only on local state.
module skid_slice
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             m_valid_q, m_valid_d;
    logic             s_valid_q, s_valid_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [WIDTH-1:0] s_data_q, s_data_d;
    logic             up_fire, dn_fire;

    assign up_ready = ~s_valid_q;
    assign dn_valid = m_valid_q;
    assign dn_data  = m_data_q;

    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_data_d  = m_data_q;
        s_data_d  = s_data_q;
        up_fire   = up_valid & ~s_valid_q;
        dn_fire   = m_valid_q & dn_ready;
        if (up_fire) begin
            // S is known empty here, so M either takes the word or it parks in S.
            if (!m_valid_q || dn_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = up_data;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = up_data;
            end
        end else if (dn_fire) begin
            if (s_valid_q) begin
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else begin
                m_valid_d = 1'b0;
            end
        end
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= {WIDTH{RST_DATA}};
            s_data_q  <= {WIDTH{RST_DATA}};
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end

endmodule

// File: rtl/pipe_register.sv
// Valid/ready pipeline register built from STAGES skid slices, with occupancy count and flush.
// Optional even-parity protection with sticky par_err when PIPE_REGISTER_PARITY_EN is defined.
module pipe_register
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = cnt_width(STAGES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
`ifdef PIPE_REGISTER_PARITY_EN
    ,
    output logic             par_err
`endif
);

`ifdef PIPE_REGISTER_PARITY_EN
    localparam int unsigned SW = WIDTH + 1;
`else
    localparam int unsigned SW = WIDTH;
`endif

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [SW-1:0]   dat [STAGES+1];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_fire, out_fire;

`ifdef PIPE_REGISTER_PARITY_EN
    assign dat[0] = {even_parity(PAR_MAX_W'(in_data)), in_data};
`else
    assign dat[0] = in_data;
`endif

    assign vld[0]      = in_valid;
    assign rdy[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_slice
        skid_slice #(
            .WIDTH(SW)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .up_valid(vld[i]),
            .up_ready(rdy[i]),
            .up_data (dat[i]),
            .dn_valid(vld[i+1]),
            .dn_ready(rdy[i+1]),
            .dn_data (dat[i+1])
        );
    end

    // Slice reset clears S.valid, so ready would read high during reset without this gate.
    assign in_ready  = rst & rdy[0];
    assign out_valid = vld[STAGES];
    assign out_data  = dat[STAGES][WIDTH-1:0];
    assign count     = cnt_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (in_fire && !out_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!in_fire && out_fire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef PIPE_REGISTER_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (out_fire && (even_parity(PAR_MAX_W'(out_data)) != dat[STAGES][WIDTH])) begin
            par_err_q <= 1'b1;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Self-checking bench for pipe_register (WIDTH=16, STAGES=2): vector table plus directed sequences.
module tb_pipe_register;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 2;
    localparam int unsigned CNT_W  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
`ifdef PIPE_REGISTER_PARITY_EN
    logic             par_err;
`endif

    pipe_register #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count)
`ifdef PIPE_REGISTER_PARITY_EN
        ,
        .par_err  (par_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Row = outputs expected in this cycle, then inputs applied for this cycle's edge.
    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             ordy;
        logic             fl;
        logic             e_ir;
        logic             e_ov;
        logic [WIDTH-1:0] e_od;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl [NVEC];

    logic [WIDTH-1:0] sb [$];

    task automatic rstep(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                         output logic accepted);
        logic ir, ov;
        @(negedge clk);
        chk("rnd_count", int'(count), sb.size());
        if (count == 3'd4) chk("rnd_full_ready", int'(in_ready), 0);
        if (sb.size() == 0) chk("rnd_empty_valid", int'(out_valid), 0);
        if (out_valid && sb.size() != 0) chk("rnd_data", int'(out_data), int'(sb[0]));
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        ir = in_ready;
        ov = out_valid;
        @(posedge clk);
        accepted = iv & ir;
        if (iv && ir) sb.push_back(d);
        if (ov && ordy && sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        logic             acc;
        logic             pend_v;
        logic [WIDTH-1:0] pend_d;
        logic [WIDTH-1:0] next_d;

        // Backpressure fill to 4, drain in order, then flush at count 3 with a live input.
        tbl[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[1]  = '{1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1};
        tbl[2]  = '{1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A1, 3'd2};
        tbl[3]  = '{1'b1, 16'h00A4, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A1, 3'd3};
        tbl[4]  = '{1'b1, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00A1, 3'd4};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A1, 3'd4};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00A2, 3'd3};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A3, 3'd2};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A4, 3'd1};
        tbl[9]  = '{1'b1, 16'h00B1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[10] = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1};
        tbl[11] = '{1'b1, 16'h00B3, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00B1, 3'd2};
        tbl[12] = '{1'b1, 16'h00B4, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00B1, 3'd3};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[14] = '{1'b1, 16'h00C1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00C1, 3'd1};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0};

        // Reset held with in_valid high.
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_in_ready", int'(in_ready), 0);
            chk("reset_out_valid", int'(out_valid), 0);
            chk("reset_count", int'(count), 0);
            chk("reset_out_data", int'(out_data), 0);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_count", int'(count), 0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].e_od));
            chk($sformatf("vec%0d_count", i), int'(count), int'(tbl[i].e_cnt));
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
        end

        // Streaming: words 1..16 presented in cycles 0..15, first visible in cycle STAGES.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stream_in_ready", int'(in_ready), 1);
            if (c >= 2 && c < 18) begin
                chk("stream_out_valid", int'(out_valid), 1);
                chk("stream_out_data", int'(out_data), c - 1);
            end else begin
                chk("stream_out_valid", int'(out_valid), 0);
            end
            if (c == 0 || c >= 18) chk("stream_count", int'(count), 0);
            else if (c == 1 || c == 17) chk("stream_count", int'(count), 1);
            else chk("stream_count", int'(count), 2);
            in_valid  = (c < 16);
            in_data   = WIDTH'(c + 1);
            out_ready = 1'b1;
        end

        // Asynchronous reset mid-stream drops everything at once.
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0;
        @(negedge clk);
        in_data = 16'h0066;
        @(negedge clk);
        in_valid = 1'b0;
        chk("midrst_pre_count", int'(count), 2);
        #2 rst = 1'b0;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst = 1'b1;

        // Random stalls against a FIFO scoreboard; inputs stay stable until accepted.
        pend_v = 1'b0;
        pend_d = '0;
        next_d = 16'h1000;
        for (int c = 0; c < 10000; c++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_d = next_d;
                next_d = next_d + 16'd1;
            end
            rstep(pend_v, pend_d, ($urandom_range(0, 2) != 0), acc);
            if (acc) pend_v = 1'b0;
        end
        for (int c = 0; c < 8; c++) rstep(1'b0, '0, 1'b1, acc);
        chk("drain_scoreboard", sb.size(), 0);
        @(negedge clk);
        chk("drain_count", int'(count), 0);
        chk("drain_out_valid", int'(out_valid), 0);

`ifdef PIPE_REGISTER_PARITY_EN
        begin
            logic [WIDTH:0] bad;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_data   = 16'h1234;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk("par_word_at_out", int'(out_valid), 1);
            chk("par_err_before", int'(par_err), 0);
            bad = dut.g_slice[1].u_slice.m_data_q;
            bad[0] = ~bad[0];
            force dut.g_slice[1].u_slice.m_data_q = bad;
            out_ready = 1'b1;
            @(posedge clk);
            #1 release dut.g_slice[1].u_slice.m_data_q;
            @(negedge clk);
            out_ready = 1'b0;
            chk("par_err_set", int'(par_err), 1);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            chk("par_err_after_flush", int'(par_err), 1);
            rst = 1'b0;
            #1 chk("par_err_reset", int'(par_err), 0);
            @(negedge clk);
            rst = 1'b1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
